out_channel_serializer: RTL and testbench
=========================================

Name: out_channel_serializer

Overview:
- Sits directly downstream of the program-execution engine's output channel.
- Each `out` instruction presents one MemoryElementWidth-bit word; this block buffers the words in a small FIFO and transmits them, in order, as asynchronous serial frames on a single wire.
- Lets a board-level test observe the whole output stream, not just finished/success.
- Reports `drained` once the program has finished and every buffered word has left the wire.

Parameters:
- MemoryElementWidth, 12: width of each output-channel word and of each frame's data field.
- FifoDepth, 8: number of buffered words; must be a power of two, at least 2.
- ClocksPerBit, 4: clock cycles per serial bit; at least 1.

Ports:
- clock, input, 1: driving clock; all state changes on its rising edge.
- reset, input, 1: asynchronous, active-low reset; low clears all state immediately, independent of clock.
- outValid, input, 1: engine presents a word this cycle.
- outData, input, MemoryElementWidth: word to transmit.
- outReady, output, 1: block can accept a word; a word is accepted on an edge where outValid and outReady are both high.
- finished, input, 1: program-finished flag from the engine.
- tx, output, 1: serial line; idle high.
- busy, output, 1: high while a frame is in flight (any state other than IDLE).
- drained, output, 1: finished has been seen, FIFO is empty and the transmitter is IDLE.
- count, output, clog2(FifoDepth)+1: current FIFO occupancy, 0..FifoDepth.

Behaviour:
- Reset (reset low):
  - tx=1, busy=0, drained=0, count=0.
  - FIFO pointers=0, finished latch=0, FSM=IDLE, bit and clock counters=0.
  - Takes effect asynchronously mid-frame; the frame in flight is abandoned and buffered words are discarded.
- outReady:
  - Equals (count != FifoDepth), from registered count only.
  - When full, no word is accepted, even if a pop occurs on the same edge.
- FIFO:
  - Circular buffer with read and write pointers modulo FifoDepth; wraps naturally.
  - Push and pop on the same edge: count unchanged, both pointers advance.
  - outData is captured on the accepting edge; no combinational path from outData to tx.
- Finished latch: sticky; set on any edge where finished=1, cleared only by reset.
- Transmitter FSM states are IDLE, START, DATA and STOP. All outputs are registered.
  - IDLE: tx=1. If count>0 at an edge, pop the head word into the shift register, load the clock counter, set tx=0 and enter START.
  - START: tx=0 for ClocksPerBit cycles, then drive tx=shift[0], reset the bit index and enter DATA.
  - DATA: each bit is held ClocksPerBit cycles, LSB first. After bit MemoryElementWidth-1, set tx=1 and enter STOP.
  - STOP: tx=1 for ClocksPerBit cycles, then return to IDLE.
- Frame timing:
  - One frame is (MemoryElementWidth+2)*ClocksPerBit cycles.
  - The IDLE dwell between frames is exactly 1 cycle when the FIFO is non-empty.
- Latency: a word accepted at edge E drives tx=0 (start bit) from edge E+1 when the FSM is IDLE at E.
- busy: 1 in START, DATA and STOP.
- drained: registered; 1 when the finished latch is set, count==0 and the FSM is IDLE.
  - Not sticky: a word accepted after finished drops drained until that word has been sent.
- Arithmetic: counters are sized from the parameters; there is no truncation of data bits.

Test Plan:
- Single word: reset low 2 cycles then high; push 12'hA5C with ClocksPerBit=4.
  - Required: tx low for 4 cycles starting edge+1.
  - Then bits 0,0,1,1,1,0,1,0,0,1,0,1 (LSB first), 4 cycles each.
  - Then high 4 cycles; busy high for exactly 56 cycles.
- Fill: with the transmitter active, push 9 words 1..9 on consecutive cycles.
  - Required: count reaches 8 and outReady goes low; word 9 is held off until the first pop.
  - Required: decoded sequence is 1..9 in order.
  - Required: the read pointer wraps past 7 without loss.
- Stream: push the output stream 1,2,3,3,33,2,22,1,11, then pulse finished.
  - Required: the 9 frames decode in that order.
  - Required: drained rises exactly one cycle after the last STOP ends and stays high.
- Simultaneous push/pop: push in the same cycle as the IDLE pop, with count=1.
  - Required: count stays 1 and the next frame starts 1 cycle after STOP.
- Mid-frame reset: assert reset during the DATA bit of the 3rd of 5 buffered words.
  - Required: tx=1, busy=0 and count=0 immediately, before the next clock edge.
  - Required: after release, no further frames are sent.
- Finished with no data: assert finished with an empty FIFO.
  - Required: drained=1 after the next edge.
  - Then push 7: drained falls the edge after acceptance and rises again after that frame.

Source files
------------

// File: rtl/out_channel_serializer.sv
// Output-channel serializer: buffers engine `out` words in a small FIFO and
// sends each one LSB first as a start/data/stop frame on a single idle-high
// wire. `drained` tells a board-level test that the program has finished and
// every buffered word has left the wire.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | line high; pops the head word as soon as the FIFO is non-empty
//   ST_START | start bit (line low) for ClocksPerBit cycles
//   ST_DATA  | data bits, LSB first, ClocksPerBit cycles each
//   ST_STOP  | stop bit (line high) for ClocksPerBit cycles
module out_channel_serializer #(
   parameter int MemoryElementWidth = 12,
   parameter int FifoDepth          = 8,
   parameter int ClocksPerBit       = 4
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          outValid,
   input  logic [MemoryElementWidth-1:0] outData,
   output logic                          outReady,
   input  logic                          finished,
   output logic                          tx,
   output logic                          busy,
   output logic                          drained,
   output logic [$clog2(FifoDepth):0]    count
);

   localparam int PtrW   = $clog2(FifoDepth);
   localparam int CountW = PtrW + 1;
   localparam int CntW   = (ClocksPerBit > 1) ? $clog2(ClocksPerBit) : 1;
   localparam int BitW   = (MemoryElementWidth > 1) ? $clog2(MemoryElementWidth) : 1;

   localparam logic [CntW-1:0]   CntLast   = CntW'(ClocksPerBit - 1);
   localparam logic [BitW-1:0]   BitLast   = BitW'(MemoryElementWidth - 1);
   localparam logic [CountW-1:0] CountFull = CountW'(FifoDepth);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } state_t;

   state_t                        state_q;
   logic [MemoryElementWidth-1:0] shift_q;
   logic [MemoryElementWidth-1:0] shift_next;
   logic [CntW-1:0]               clk_cnt_q;
   logic [BitW-1:0]               bit_idx_q;
   logic                          tx_q;
   logic                          busy_q;
   logic                          drained_q;
   logic                          fin_q;

   logic [MemoryElementWidth-1:0] mem_q [FifoDepth];
   logic [PtrW-1:0]               wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]               rd_ptr_q, rd_ptr_d;
   logic [CountW-1:0]             count_q, count_d;

   logic push;
   logic pop;

   // Readiness comes only from the registered occupancy, so a pop on the same
   // edge never lets a word into a full FIFO.
   assign outReady   = (count_q != CountFull);
   assign push       = outValid & outReady;
   assign pop        = (state_q == ST_IDLE) && (count_q != '0);
   assign shift_next = shift_q >> 1;

   assign tx      = tx_q;
   assign busy    = busy_q;
   assign drained = drained_q;
   assign count   = count_q;

   // Next-state for pointers and occupancy; pointers wrap at the power-of-two depth.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CountW'(1);
         2'b01:   count_d = count_q - CountW'(1);
         default: count_d = count_q;
      endcase
   end

   // FIFO storage; contents need no reset because the pointers define validity.
   always_ff @(posedge clock) begin
      if (push) begin
         mem_q[wr_ptr_q] <= outData;
      end
   end

   // FIFO pointers, occupancy, sticky finished latch and the drained flag.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         fin_q     <= 1'b0;
         drained_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         fin_q     <= fin_q | finished;
         drained_q <= fin_q && (count_q == '0) && (state_q == ST_IDLE);
      end
   end

   // Transmitter: frame sequencing with registered line and busy outputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         clk_cnt_q <= '0;
         bit_idx_q <= '0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               tx_q   <= 1'b1;
               busy_q <= 1'b0;
               if (pop) begin
                  shift_q   <= mem_q[rd_ptr_q];
                  clk_cnt_q <= CntLast;
                  tx_q      <= 1'b0;
                  busy_q    <= 1'b1;
                  state_q   <= ST_START;
               end
            end
            ST_START: begin
               if (clk_cnt_q == '0) begin
                  tx_q      <= shift_q[0];
                  bit_idx_q <= '0;
                  clk_cnt_q <= CntLast;
                  state_q   <= ST_DATA;
               end else begin
                  clk_cnt_q <= clk_cnt_q - CntW'(1);
               end
            end
            ST_DATA: begin
               if (clk_cnt_q == '0) begin
                  clk_cnt_q <= CntLast;
                  if (bit_idx_q == BitLast) begin
                     tx_q    <= 1'b1;
                     state_q <= ST_STOP;
                  end else begin
                     shift_q   <= shift_next;
                     tx_q      <= shift_next[0];
                     bit_idx_q <= bit_idx_q + BitW'(1);
                  end
               end else begin
                  clk_cnt_q <= clk_cnt_q - CntW'(1);
               end
            end
            ST_STOP: begin
               if (clk_cnt_q == '0) begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end else begin
                  clk_cnt_q <= clk_cnt_q - CntW'(1);
               end
            end
            default: begin
               tx_q    <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_out_channel_serializer.sv
// Bench for out_channel_serializer: a frame-level reference model (queue of
// words, a frame position counter) is stepped every clock and compared with
// the DUT, a line decoder rebuilds words from tx, and directed steps cover
// the single-word waveform, fill, streaming, push/pop overlap, mid-frame
// reset and finished-without-data cases.
module tb_out_channel_serializer;

   localparam int W     = 12;
   localparam int DEPTH = 8;
   localparam int CPB   = 4;
   localparam int FRAME = (W + 2) * CPB;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clock    = 1'b0;
   logic          reset    = 1'b0;
   logic          outValid = 1'b0;
   logic [W-1:0]  outData  = '0;
   logic          finished = 1'b0;
   logic          outReady;
   logic          tx;
   logic          busy;
   logic          drained;
   logic [CW-1:0] count;

   out_channel_serializer #(
      .MemoryElementWidth(W),
      .FifoDepth(DEPTH),
      .ClocksPerBit(CPB)
   ) dut (
      .clock(clock),
      .reset(reset),
      .outValid(outValid),
      .outData(outData),
      .outReady(outReady),
      .finished(finished),
      .tx(tx),
      .busy(busy),
      .drained(drained),
      .count(count)
   );

   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;

   // reference model
   logic [W-1:0] m_q[$];
   logic [W-1:0] sent[$];
   int           m_rem = 0;
   logic [W-1:0] m_word = '0;
   bit           m_fin = 0;
   bit           m_drained = 0;
   bit           m_acc = 0;
   int           m_frames = 0;

   // line decoder and monitors
   logic [W-1:0] rx_q[$];
   bit           rx_active = 0;
   int           rx_cyc = 0;
   logic [W-1:0] rx_word = '0;
   int           cyc = 0;
   int           fall_cyc = 0;
   int           last_gap = 0;
   int           drain_rise_cyc = 0;
   logic         prev_busy = 1'b0;
   logic         prev_drained = 1'b0;
   int           max_count = 0;
   bit           saw_not_ready = 0;
   int           busy_hits = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic fail_timeout(input string tag);
      checks++;
      errors++;
      $error("FAIL timeout %s: observed=expired expected=event", tag);
   endtask

   function automatic logic m_tx();
      int pos;
      int b;
      if (m_rem == 0) return 1'b1;
      pos = FRAME - m_rem;
      b   = pos / CPB;
      if (b == 0) return 1'b0;
      if (b <= W) return m_word[b-1];
      return 1'b1;
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_rem     = 0;
      m_fin     = 0;
      m_drained = 0;
      m_acc     = 0;
      rx_active = 0;
   endtask

   task automatic model_edge();
      bit pop;
      bit nd;
      pop   = (m_rem == 0) && (m_q.size() > 0);
      m_acc = outValid && (m_q.size() != DEPTH);
      nd    = m_fin && (m_q.size() == 0) && (m_rem == 0);
      if (pop) begin
         m_word = m_q.pop_front();
         m_rem  = FRAME;
         m_frames++;
      end else if (m_rem > 0) begin
         m_rem--;
      end
      if (m_acc) begin
         m_q.push_back(outData);
         sent.push_back(outData);
      end
      if (finished) m_fin = 1;
      m_drained = nd;
   endtask

   task automatic tick();
      @(posedge clock);
      if (!reset) model_reset();
      else model_edge();
      #1;
      cyc++;
      chk("tx", 32'(tx), 32'(m_tx()));
      chk("busy", 32'(busy), 32'(m_rem != 0));
      chk("count", 32'(count), 32'(m_q.size()));
      chk("outReady", 32'(outReady), 32'(m_q.size() != DEPTH));
      chk("drained", 32'(drained), 32'(m_drained));
      if (prev_busy && !busy) fall_cyc = cyc;
      if (!prev_busy && busy) last_gap = cyc - fall_cyc;
      if (!prev_drained && drained) drain_rise_cyc = cyc;
      prev_busy    = busy;
      prev_drained = drained;
      if (int'(count) > max_count) max_count = int'(count);
      if (!outReady) saw_not_ready = 1;
      if (busy) busy_hits++;
      if (!reset) begin
         rx_active = 0;
      end else if (!rx_active) begin
         if (tx === 1'b0) begin
            rx_active = 1;
            rx_cyc    = 0;
            rx_word   = '0;
         end
      end else begin
         rx_cyc++;
         if (rx_cyc >= CPB && rx_cyc < CPB * (W + 1) && (rx_cyc % CPB) == CPB / 2)
            rx_word[rx_cyc / CPB - 1] = tx;
         if (rx_cyc == CPB * (W + 1) + CPB / 2) begin
            chk("rx_stop", 32'(tx), 32'd1);
            rx_q.push_back(rx_word);
            rx_active = 0;
         end
      end
   endtask

   task automatic push_word(input logic [W-1:0] d);
      int n;
      n        = 0;
      outValid = 1'b1;
      outData  = d;
      do begin
         tick();
         n++;
      end while (!m_acc && n < 200);
      if (!m_acc) fail_timeout("push");
      outValid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while ((m_rem != 0 || m_q.size() != 0) && n < 3000) begin
         tick();
         n++;
      end
      if (m_rem != 0 || m_q.size() != 0) fail_timeout(tag);
      tick();
   endtask

   task automatic check_rx(input string tag, input logic [W-1:0] exp[$]);
      chk({tag, "_len"}, 32'(rx_q.size()), 32'(exp.size()));
      for (int i = 0; i < exp.size() && i < rx_q.size(); i++)
         chk({tag, "_word"}, 32'(rx_q[i]), 32'(exp[i]));
      rx_q.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic         s1 [60];
      bit           exp_bits [12];
      int           nbusy;
      int           f0;
      int           n;
      logic [W-1:0] exp_q[$];
      logic [W-1:0] wa;
      logic [W-1:0] wb;

      exp_bits = '{0, 0, 1, 1, 1, 0, 1, 0, 0, 1, 0, 1};

      // reset held low two cycles
      reset = 1'b0;
      tick();
      tick();
      chk("rst_tx", 32'(tx), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_drained", 32'(drained), 32'd0);
      chk("rst_ready", 32'(outReady), 32'd1);
      reset = 1'b1;
      tick();

      // single word waveform
      push_word(12'hA5C);
      nbusy = 0;
      for (int k = 0; k < 60; k++) begin
         tick();
         s1[k] = tx;
         if (busy) nbusy++;
      end
      for (int k = 0; k < 60; k++) begin
         if (k < 4) chk("t1_start", 32'(s1[k]), 32'd0);
         else if (k < 52) chk("t1_data", 32'(s1[k]), 32'(exp_bits[(k - 4) / 4]));
         else chk("t1_stop_idle", 32'(s1[k]), 32'd1);
      end
      chk("t1_busy_len", 32'(nbusy), 32'd56);
      exp_q = {};
      exp_q.push_back(12'hA5C);
      check_rx("t1_rx", exp_q);

      // fill past depth while transmitting
      max_count     = 0;
      saw_not_ready = 0;
      exp_q         = {};
      push_word(12'h3C3);
      exp_q.push_back(12'h3C3);
      for (int w = 1; w <= 9; w++) begin
         push_word(W'(w));
         exp_q.push_back(W'(w));
      end
      wait_idle("t2_drain");
      chk("t2_max_count", 32'(max_count), 32'd8);
      chk("t2_not_ready", 32'(saw_not_ready), 32'd1);
      check_rx("t2_rx", exp_q);

      // push on the same edge as the idle pop
      wa = W'($urandom);
      wb = W'($urandom);
      push_word(wa);
      push_word(wb);
      chk("t3_count", 32'(count), 32'd1);
      wait_idle("t3_drain");
      chk("t3_gap", 32'(last_gap), 32'd1);
      exp_q = {};
      exp_q.push_back(wa);
      exp_q.push_back(wb);
      check_rx("t3_rx", exp_q);

      // randomized traffic
      sent.delete();
      for (int i = 0; i < 30; i++) begin
         repeat ($urandom_range(0, 3)) tick();
         push_word(W'($urandom));
      end
      wait_idle("rand_drain");
      check_rx("rand_rx", sent);

      // program output stream followed by finished
      exp_q = {};
      exp_q.push_back(12'd1);
      exp_q.push_back(12'd2);
      exp_q.push_back(12'd3);
      exp_q.push_back(12'd3);
      exp_q.push_back(12'd33);
      exp_q.push_back(12'd2);
      exp_q.push_back(12'd22);
      exp_q.push_back(12'd1);
      exp_q.push_back(12'd11);
      foreach (exp_q[i]) begin
         repeat ($urandom_range(0, 2)) tick();
         push_word(exp_q[i]);
      end
      finished = 1'b1;
      tick();
      finished = 1'b0;
      n = 0;
      while (!m_drained && n < 3000) begin
         tick();
         n++;
      end
      if (!m_drained) fail_timeout("t4_drained");
      chk("t4_drain_delay", 32'(drain_rise_cyc - fall_cyc), 32'd1);
      repeat (10) tick();
      chk("t4_drained_held", 32'(drained), 32'd1);
      check_rx("t4_rx", exp_q);

      // asynchronous reset in the middle of the third frame
      f0    = m_frames;
      exp_q = {};
      for (int i = 0; i < 5; i++) begin
         wa = W'($urandom);
         exp_q.push_back(wa);
         push_word(wa);
      end
      n = 0;
      while (!(m_frames == f0 + 3 && m_rem == FRAME - 20) && n < 1000) begin
         tick();
         n++;
      end
      if (!(m_frames == f0 + 3 && m_rem == FRAME - 20)) fail_timeout("t5_frame3");
      reset = 1'b0;
      #1;
      chk("t5_tx_now", 32'(tx), 32'd1);
      chk("t5_busy_now", 32'(busy), 32'd0);
      chk("t5_count_now", 32'(count), 32'd0);
      model_reset();
      exp_q = exp_q[0:1];
      check_rx("t5_rx_before", exp_q);
      tick();
      tick();
      reset     = 1'b1;
      busy_hits = 0;
      repeat (150) tick();
      chk("t5_no_busy", 32'(busy_hits), 32'd0);
      chk("t5_no_frames", 32'(rx_q.size()), 32'd0);

      // finished with nothing buffered, then one more word
      finished = 1'b1;
      tick();
      finished = 1'b0;
      tick();
      chk("t6_drained", 32'(drained), 32'd1);
      push_word(12'd7);
      chk("t6_drained_at_accept", 32'(drained), 32'd1);
      tick();
      chk("t6_drained_fall", 32'(drained), 32'd0);
      n = 0;
      while (!m_drained && n < 200) begin
         tick();
         n++;
      end
      if (!m_drained) fail_timeout("t6_drained_rise");
      chk("t6_drain_delay", 32'(drain_rise_cyc - fall_cyc), 32'd1);
      exp_q = {};
      exp_q.push_back(12'd7);
      check_rx("t6_rx", exp_q);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
